// File: rtl/instr_issue_queue.sv
// Purpose : in-order instruction issue FIFO that inserts NOP bubbles on RAW hazards.
// Latency : 1 cycle from push into an empty, hazard-free queue to out_instr.
// Backpr. : in_ready drops when the FIFO is full; hold freezes issue but not pushes.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_instr   instruction word from the loader, qualified by in_valid
//   in_valid   loader has a word on in_instr
//   in_ready   queue can accept a word (registered count only)
//   hold       core stall; freezes out_instr/out_pc/bubble, hazard history and head
//   out_instr  registered instruction (FIFO head or NOP)
//   out_pc     registered byte address of the last real issued instruction
//   bubble     registered; 1 when out_instr is an inserted NOP
module instr_issue_queue #(
  parameter int          DEPTH      = 4,
  parameter int          HAZ_WINDOW = 2,
  parameter logic [31:0] NOP        = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_instr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        hold,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        bubble
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  // hist[0] is the most recently issued destination; 0 means "no destination".
  logic [4:0]    hist [HAZ_WINDOW];
  logic          pc_started;

  logic          push;
  logic          issue;
  logic          hazard;
  logic [31:0]   head;
  logic [6:0]    head_op;
  logic [4:0]    head_rd;
  logic [4:0]    head_rs1;
  logic [4:0]    head_rs2;
  logic          rs1_used;
  logic          rs2_used;

  // Acceptance depends only on the registered count, so a full queue refuses
  // a push even in a cycle where it also pops.
  assign in_ready = !rst && (count < FULL);
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];

  always_comb begin
    head_op  = head[6:0];
    head_rs1 = head[19:15];
    head_rs2 = head[24:20];
    head_rd  = 5'd0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (head_op)
      7'b0010011: begin head_rd = head[11:7]; rs1_used = 1'b1; end
      7'b0110011: begin head_rd = head[11:7]; rs1_used = 1'b1; rs2_used = 1'b1; end
      7'b0110111,
      7'b0010111: head_rd = head[11:7];
      7'b1100011: begin rs1_used = 1'b1; rs2_used = 1'b1; end
      default: ;
    endcase

    // A zero history slot never matches, which also keeps x0 out of the check.
    hazard = 1'b0;
    for (int i = 0; i < HAZ_WINDOW; i++) begin
      if (hist[i] != 5'd0) begin
        if (rs1_used && (head_rs1 == hist[i])) hazard = 1'b1;
        if (rs2_used && (head_rs2 == hist[i])) hazard = 1'b1;
      end
    end

    issue = !hold && (count != '0) && !hazard;
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_instr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      out_instr  <= NOP;
      out_pc     <= 32'd0;
      bubble     <= 1'b1;
      pc_started <= 1'b0;
      for (int i = 0; i < HAZ_WINDOW; i++) hist[i] <= 5'd0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push)  wr_ptr <= wr_ptr + AW'(1);
      if (issue) rd_ptr <= rd_ptr + AW'(1);

      case ({push, issue})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase

      if (!hold) begin
        hist[0] <= issue ? head_rd : 5'd0;
        for (int i = 1; i < HAZ_WINDOW; i++) hist[i] <= hist[i-1];
        if (issue) begin
          out_instr  <= head;
          bubble     <= 1'b0;
          // First real issue after reset is address 0; later ones step by 4.
          out_pc     <= pc_started ? out_pc + 32'd4 : 32'd0;
          pc_started <= 1'b1;
        end else begin
          out_instr <= NOP;
          bubble    <= 1'b1;
        end
      end
    end
  end

endmodule
